// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter:
//     BYTE_W       width of one transmitted byte
//     arb_state_t  arbiter FSM states (IDLE, OWN, GAP)
//     tout_width   width of the hold-timeout counter for a given timeout
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // Enough bits to hold HOLD_TIMEOUT itself; at least one bit so that a
  // disabled timeout (0) still yields a legal vector.
  function automatic int tout_width(input int hold);
    return (hold <= 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_rr_pick
//   Combinational round-robin picker. Selects the first asserted request at
//   or after the pointer position, wrapping modulo NUM_REQ.
// Ports
//   req    in   NUM_REQ  request vector
//   ptr    in   PTR_W    search start position (always < NUM_REQ)
//   grant  out  NUM_REQ  one-hot winner, zero when no request
//   idx    out  PTR_W    binary index of the winner
//   valid  out  1        at least one request present
// ---------------------------------------------------------------------------
module uart_tx_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   first_hit;
  logic [2*NUM_REQ-1:0] hit_dbl;

  // Rotate the request vector right by ptr so that bit 0 is the pointer
  // position; a fixed priority search then implements round-robin.
  assign req_dbl = {req, req};
  assign rot_req = NUM_REQ'(req_dbl >> ptr);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_first
    if (gi == 0) begin : g_lsb
      assign first_hit[gi] = rot_req[gi];
    end else begin : g_upper
      assign first_hit[gi] = rot_req[gi] & ~(|rot_req[gi-1:0]);
    end
  end

  // Rotate the winner back left by ptr into absolute requester positions.
  assign hit_dbl = {first_hit, first_hit};
  assign grant   = NUM_REQ'((hit_dbl << ptr) >> NUM_REQ);
  assign valid   = |req;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares the single uart_tx6 transmit FIFO between NUM_REQ byte-stream
//   requesters. Round-robin grant at packet granularity: an owner keeps the
//   transmitter until its byte flagged last has been written. One byte per
//   two cycles at most; a dead GAP cycle follows every write so tx_full is
//   up to date before the next write decision.
// Ports
//   gclk1     in   1          system clock
//   rst_n     in   1          asynchronous active-low reset
//   req       in   NUM_REQ    requester i presents a byte, held until ack[i]
//   req_data  in   8*NUM_REQ  packed byte per requester
//   req_last  in   NUM_REQ    presented byte ends the requester's packet
//   ack       out  NUM_REQ    1-cycle pulse: requester's byte was written
//   grant     out  NUM_REQ    one-hot current owner, zero when idle
//   tx_data   out  8          to uart_tx6 data_in
//   tx_write  out  1          to uart_tx6 buffer_write, 1-cycle pulse
//   tx_full   in   1          from uart_tx6 buffer_full
//   busy      out  1          a packet is in progress
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int PTR_W        = 3
) (
  input  logic                      gclk1,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_write,
  input  logic                      tx_full,
  output logic                      busy
);

  localparam int                TOUT_W     = tout_width(HOLD_TIMEOUT);
  localparam logic [TOUT_W-1:0] TOUT_MAX   = '1;
  localparam logic [TOUT_W-1:0] TOUT_LIMIT = TOUT_W'(HOLD_TIMEOUT);
  localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(NUM_REQ - 1);

  arb_state_t         state_reg, state_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [PTR_W-1:0]   owner_reg, owner_next;
  logic [TOUT_W-1:0]  tout_reg, tout_next;
  logic               last_reg, last_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic [BYTE_W-1:0]  tx_data_reg, tx_data_next;
  logic               tx_write_reg, tx_write_next;
  logic               busy_reg, busy_next;

  logic [NUM_REQ-1:0] pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;

  logic               owner_req;
  logic               owner_last;
  logic [BYTE_W-1:0]  owner_data;
  logic [BYTE_W-1:0]  masked_data [NUM_REQ];
  logic [PTR_W-1:0]   ptr_after_owner;
  logic [TOUT_W-1:0]  tout_inc;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Owner-side view of the request bus, selected by the one-hot grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign masked_data[gi] = req_data[gi*BYTE_W +: BYTE_W] & {BYTE_W{grant_reg[gi]}};
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_data = owner_data | masked_data[i];
    end
  end

  assign owner_req       = |(req & grant_reg);
  assign owner_last      = |(req_last & grant_reg);
  assign ptr_after_owner = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
  // Saturating increment: the counter never wraps back to zero.
  assign tout_inc        = (tout_reg == TOUT_MAX) ? tout_reg : tout_reg + 1'b1;

  always_ff @(posedge gclk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      tout_reg     <= '0;
      last_reg     <= 1'b0;
      grant_reg    <= '0;
      ack_reg      <= '0;
      tx_data_reg  <= '0;
      tx_write_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      tout_reg     <= tout_next;
      last_reg     <= last_next;
      grant_reg    <= grant_next;
      ack_reg      <= ack_next;
      tx_data_reg  <= tx_data_next;
      tx_write_reg <= tx_write_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    tout_next     = tout_reg;
    last_next     = last_reg;
    grant_next    = grant_reg;
    ack_next      = '0;
    tx_data_next  = tx_data_reg;
    tx_write_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_next = pick_grant;
          owner_next = pick_idx;
          tout_next  = '0;
          state_next = ST_OWN;
        end
      end

      ST_OWN: begin
        if (owner_req) begin
          // A requesting owner never times out, even when the FIFO is full.
          tout_next = '0;
          if (!tx_full) begin
            tx_data_next  = owner_data;
            tx_write_next = 1'b1;
            ack_next      = grant_reg;
            last_next     = owner_last;
            state_next    = ST_GAP;
          end
        end else begin
          tout_next = tout_inc;
          if ((HOLD_TIMEOUT != 0) && (tout_inc == TOUT_LIMIT)) begin
            grant_next = '0;
            ptr_next   = ptr_after_owner;
            tout_next  = '0;
            state_next = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (last_reg) begin
          grant_next = '0;
          ptr_next   = ptr_after_owner;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_OWN;
        end
      end

      default: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end
    endcase

    busy_next = |grant_next;
  end

  assign ack      = ack_reg;
  assign grant    = grant_reg;
  assign tx_data  = tx_data_reg;
  assign tx_write = tx_write_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed scenarios followed by randomized two-requester traffic against
//   a 16-deep FIFO model. Expected bytes come from per-requester packet
//   streams held in the bench; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic        gclk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic        tx_full;
  logic [1:0]  ack;
  logic [1:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // Per-requester byte streams (packets laid end to end).
  logic [7:0] byte_mem [2][64];
  bit         last_mem [2][64];
  int         len [2];
  int         pos [2];
  int         gap [2];
  int         fifo_cnt;
  int         drain_mod;
  int         max_gap;
  int         open_owner;
  int         order_log [$];

  uart_tx_arbiter #(
    .NUM_REQ      (2),
    .HOLD_TIMEOUT (8),
    .PTR_W        (3)
  ) dut (
    .gclk1    (gclk1),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ack      (ack),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_write (tx_write),
    .tx_full  (tx_full),
    .busy     (busy)
  );

  always #5 gclk1 = ~gclk1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge gclk1);
  endtask

  task automatic drive(input int k, input logic on, input logic [7:0] d, input logic l);
    req[k]            = on;
    req_data[k*8 +: 8] = d;
    req_last[k]       = l;
  endtask

  task automatic expect_write(input string tag, input logic [7:0] d, input logic [1:0] a);
    check({tag, "_write"}, tx_write, 1'b1);
    check({tag, "_data"}, tx_data, d);
    check({tag, "_ack"}, ack, a);
    $display("[TB] %s: write data %02h ack %b", tag, tx_data, ack);
  endtask

  task automatic clear_streams();
    for (int k = 0; k < 2; k++) begin
      len[k] = 0;
      pos[k] = 0;
      gap[k] = 0;
    end
    order_log.delete();
  endtask

  task automatic put_byte(input int k, input logic [7:0] d, input bit l);
    byte_mem[k][len[k]] = d;
    last_mem[k][len[k]] = l;
    len[k]++;
  endtask

  task automatic gen_stream(input int k, input int npk, input int maxlen);
    for (int p = 0; p < npk; p++) begin
      int plen;
      plen = $urandom_range(1, maxlen);
      for (int b = 0; b < plen; b++) begin
        put_byte(k, 8'($urandom), b == plen - 1);
      end
    end
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < 2; k++) begin
      if (gap[k] > 0) begin
        gap[k]--;
        drive(k, 1'b0, 8'h00, 1'b0);
      end else if (pos[k] < len[k]) begin
        drive(k, 1'b1, byte_mem[k][pos[k]], last_mem[k][pos[k]]);
      end else begin
        drive(k, 1'b0, 8'h00, 1'b0);
      end
    end
  endtask

  // Plays both requesters' streams through the DUT with a draining FIFO
  // model and checks every handshake against the streams.
  task automatic run_engine(input int budget);
    int  cyc;
    int  k;
    bit  done;
    cyc        = 0;
    open_owner = -1;
    fifo_cnt   = 0;
    tx_full    = 1'b0;
    drive_reqs();
    done = 1'b0;
    while (!done && cyc < budget) begin
      step();
      cyc++;
      if (tx_write) begin
        check("fifo_not_full_at_write", fifo_cnt < 16, 1'b1);
        fifo_cnt++;
      end
      if (tx_write || ack != 2'b00) begin
        check("ack_with_write", {tx_write, $onehot(ack)}, 2'b11);
        if (ack != 2'b00) begin
          k = ack[1] ? 1 : 0;
          check("ack_expected", pos[k] < len[k], 1'b1);
          if (pos[k] < len[k]) begin
            check("byte_order", tx_data, byte_mem[k][pos[k]]);
            if (open_owner >= 0) check("no_interleave", k, open_owner);
            order_log.push_back(k);
            $display("[TB] write req%0d byte %02h last %0d", k, tx_data, last_mem[k][pos[k]]);
            if (last_mem[k][pos[k]]) begin
              open_owner = -1;
              gap[k]     = $urandom_range(0, max_gap);
            end else begin
              open_owner = k;
            end
            pos[k]++;
          end
        end
      end
      if (fifo_cnt > 0 && $urandom_range(0, drain_mod - 1) == 0) fifo_cnt--;
      tx_full = (fifo_cnt >= 16);
      drive_reqs();
      done = (pos[0] >= len[0]) && (pos[1] >= len[1]) && !busy;
    end
    check("engine_done_in_budget", done, 1'b1);
    check("all_bytes_req0", pos[0], len[0]);
    check("all_bytes_req1", pos[1], len[1]);
    tx_full = 1'b0;
  endtask

  initial begin
    int bad;
    int held;
    req      = 2'b00;
    req_data = 16'h0000;
    req_last = 2'b00;
    tx_full  = 1'b0;
    drain_mod = 1;
    max_gap   = 0;
    clear_streams();

    // ---- reset state ----
    step();
    step();
    check("rst_ack", ack, 2'b00);
    check("rst_grant", grant, 2'b00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_write", tx_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    check("post_rst_idle", grant, 2'b00);

    // ---- 1: single 3-byte packet from req0 ----
    drive(0, 1'b1, 8'h41, 1'b0);
    step();
    check("t1_grant", grant, 2'b01);
    check("t1_busy", busy, 1'b1);
    check("t1_no_write_at_grant", tx_write, 1'b0);
    step();
    expect_write("t1_b0", 8'h41, 2'b01);
    drive(0, 1'b1, 8'h42, 1'b0);
    step();
    check("t1_gap1", {tx_write, ack}, 3'b000);
    step();
    expect_write("t1_b1", 8'h42, 2'b01);
    drive(0, 1'b1, 8'h43, 1'b1);
    step();
    check("t1_gap2", {tx_write, ack}, 3'b000);
    step();
    expect_write("t1_b2", 8'h43, 2'b01);
    drive(0, 1'b0, 8'h00, 1'b0);
    step();
    check("t1_release_grant", grant, 2'b00);
    check("t1_release_busy", busy, 1'b0);

    // ---- 2: contention; pointer is 1 after test 1, so req1 first ----
    drain_mod = 1;
    max_gap   = 0;
    clear_streams();
    put_byte(1, 8'hB0, 1'b1);
    run_engine(100);
    check("t2_pre_count", order_log.size(), 1);
    if (order_log.size() == 1) check("t2_pre_owner", order_log[0], 1);

    clear_streams();
    put_byte(0, 8'hA0, 1'b0);
    put_byte(0, 8'hA1, 1'b1);
    put_byte(1, 8'hB1, 1'b0);
    put_byte(1, 8'hB2, 1'b1);
    run_engine(100);
    check("t2_count", order_log.size(), 4);
    if (order_log.size() == 4) begin
      check("t2_order0", order_log[0], 0);
      check("t2_order1", order_log[1], 0);
      check("t2_order2", order_log[2], 1);
      check("t2_order3", order_log[3], 1);
    end

    clear_streams();
    put_byte(0, 8'hA2, 1'b1);
    put_byte(1, 8'hB3, 1'b1);
    run_engine(100);
    check("t2_wrap_count", order_log.size(), 2);
    if (order_log.size() == 2) begin
      check("t2_wrap_first", order_log[0], 0);
      check("t2_wrap_second", order_log[1], 1);
    end

    // ---- 3: FIFO full during OWN ----
    tx_full = 1'b1;
    drive(0, 1'b1, 8'h55, 1'b1);
    drive(1, 1'b0, 8'h00, 1'b0);
    step();
    check("t3_grant", grant, 2'b01);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx_write || ack != 2'b00 || grant != 2'b01) bad++;
    end
    check("t3_hold_while_full", bad, 0);
    tx_full = 1'b0;
    step();
    expect_write("t3_after_full", 8'h55, 2'b01);
    drive(0, 1'b0, 8'h00, 1'b0);
    step();
    check("t3_release", grant, 2'b00);

    // ---- 4: owner stalls mid-packet, HOLD_TIMEOUT=8 ----
    drive(0, 1'b1, 8'h61, 1'b0);
    step();
    check("t4_grant0", grant, 2'b01);
    step();
    expect_write("t4_b0", 8'h61, 2'b01);
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b1, 8'h71, 1'b1);
    held = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (grant == 2'b01 && !tx_write) held++;
    end
    check("t4_held_8", held, 8);
    step();
    check("t4_released", grant, 2'b00);
    step();
    check("t4_grant1", grant, 2'b10);
    step();
    expect_write("t4_req1", 8'h71, 2'b10);
    drive(1, 1'b0, 8'h00, 1'b0);
    step();
    check("t4_idle", grant, 2'b00);

    // ---- 5: reset during GAP ----
    clear_streams();
    put_byte(0, 8'h90, 1'b1);
    run_engine(100);
    drive(1, 1'b1, 8'h81, 1'b0);
    step();
    check("t5_grant1", grant, 2'b10);
    step();
    expect_write("t5_b0", 8'h81, 2'b10);
    rst_n = 1'b0;
    #1;
    check("t5_async_outputs", {ack, grant, tx_data, tx_write, busy}, 14'h0000);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (tx_write || grant != 2'b00) bad++;
    end
    check("t5_quiet_in_reset", bad, 0);
    rst_n = 1'b1;
    drive(0, 1'b1, 8'hC0, 1'b1);
    drive(1, 1'b1, 8'hC1, 1'b1);
    step();
    check("t5_ptr_reset_grant", grant, 2'b01);
    check("t5_no_spurious_write", tx_write, 1'b0);
    step();
    expect_write("t5_after_rst", 8'hC0, 2'b01);
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    step();
    check("t5_idle", grant, 2'b00);
    step();

    // ---- 6: random traffic with a slowly draining 16-deep FIFO ----
    clear_streams();
    drain_mod = 4;
    max_gap   = 5;
    gen_stream(0, 12, 4);
    gen_stream(1, 12, 4);
    run_engine(6000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
